// File: rtl/led_share_sched.sv
// led_share_sched: round-robin time-sharing of one RGB LED between N_REQ
// requesters, with global PWM brightness and an idle colour-cycling pattern.
module led_share_sched #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned PWM_W     = 8,
   parameter int unsigned HOLD_W    = 32,
   parameter int unsigned IDLE_STEP = 24_000_000
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [N_REQ-1:0]         i_req,
   input  logic [3*N_REQ-1:0]       i_colour,
   input  logic [HOLD_W*N_REQ-1:0]  i_hold,
   input  logic [PWM_W-1:0]         i_duty,
   output logic [N_REQ-1:0]         o_grant,
   output logic                     o_busy,
   output logic                     o_ledr,
   output logic                     o_ledg,
   output logic                     o_ledb
);

   localparam int unsigned IDX_W  = $clog2(N_REQ);
   localparam int unsigned STEP_W = (IDLE_STEP > 1) ? $clog2(IDLE_STEP) : 1;
   localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(N_REQ - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(IDLE_STEP - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SHOW = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    last, last_nxt;
   logic [2:0]          idle_col, idle_col_nxt;
   logic [STEP_W-1:0]   step_cnt, step_cnt_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
   logic [HOLD_W-1:0]   cap_hold, cap_hold_nxt;
   logic [2:0]          cap_col, cap_col_nxt;
   logic [PWM_W-1:0]    pwm_cnt;
   logic [N_REQ-1:0]    grant_nxt;

   logic                any_req_c;
   logic [IDX_W-1:0]    win_c;
   logic [N_REQ-1:0]    win_oh_c;
   logic [2:0]          sel_col_c;
   logic [HOLD_W-1:0]   sel_hold_c;
   logic [2:0]          disp_c;
   logic                hold_done_c;
   logic                pwm_on_c;

   // Round-robin search starting just after the last winner, plus winner's payload
   always_comb begin
      int unsigned idx;
      idx        = 0;
      any_req_c  = 1'b0;
      win_c      = '0;
      win_oh_c   = '0;
      sel_col_c  = '0;
      sel_hold_c = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = 32'(last) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!any_req_c && i_req[IDX_W'(idx)]) begin
            any_req_c = 1'b1;
            win_c     = IDX_W'(idx);
         end
      end
      for (int k = 0; k < int'(N_REQ); k++) begin
         if (win_c == IDX_W'(k)) begin
            win_oh_c[k] = 1'b1;
            sel_col_c   = i_colour[3*k +: 3];
            sel_hold_c  = i_hold[HOLD_W*k +: HOLD_W];
         end
      end
   end

   // SHOW ends after max(hold,1) cycles; PWM compare is against the live duty
   assign hold_done_c = (cap_hold <= HOLD_W'(1)) || (hold_cnt == cap_hold - HOLD_W'(1));
   assign pwm_on_c    = (pwm_cnt < i_duty);

   // Next-state, arbitration and displayed-colour selection
   always_comb begin
      state_nxt    = state;
      last_nxt     = last;
      idle_col_nxt = idle_col;
      step_cnt_nxt = step_cnt;
      hold_cnt_nxt = hold_cnt;
      cap_hold_nxt = cap_hold;
      cap_col_nxt  = cap_col;
      grant_nxt    = '0;
      disp_c       = 3'b000;
      unique case (state)
         S_IDLE: begin
            disp_c = idle_col;
            if (any_req_c) begin
               state_nxt    = S_SHOW;
               last_nxt     = win_c;
               cap_col_nxt  = sel_col_c;
               cap_hold_nxt = sel_hold_c;
               hold_cnt_nxt = '0;
               grant_nxt    = win_oh_c;
            end else if (step_cnt == STEP_LAST) begin
               step_cnt_nxt = '0;
               idle_col_nxt = idle_col + 3'd1;
            end else begin
               step_cnt_nxt = step_cnt + STEP_W'(1);
            end
         end
         S_SHOW: begin
            disp_c = cap_col;
            if (hold_done_c) begin
               state_nxt = S_GAP;
            end else begin
               hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         S_GAP: begin
            disp_c = 3'b000;
            if (any_req_c) begin
               state_nxt    = S_SHOW;
               last_nxt     = win_c;
               cap_col_nxt  = sel_col_c;
               cap_hold_nxt = sel_hold_c;
               hold_cnt_nxt = '0;
               grant_nxt    = win_oh_c;
            end else begin
               state_nxt    = S_IDLE;
               step_cnt_nxt = '0;
               idle_col_nxt = '0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= S_IDLE;
         last     <= LAST_RST;
         idle_col <= '0;
         step_cnt <= '0;
         hold_cnt <= '0;
         cap_hold <= '0;
         cap_col  <= '0;
         pwm_cnt  <= '0;
         o_grant  <= '0;
         o_busy   <= 1'b0;
         o_ledr   <= 1'b0;
         o_ledg   <= 1'b0;
         o_ledb   <= 1'b0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         idle_col <= idle_col_nxt;
         step_cnt <= step_cnt_nxt;
         hold_cnt <= hold_cnt_nxt;
         cap_hold <= cap_hold_nxt;
         cap_col  <= cap_col_nxt;
         pwm_cnt  <= pwm_cnt + PWM_W'(1);
         o_grant  <= grant_nxt;
         o_busy   <= (state != S_IDLE);
         {o_ledr, o_ledg, o_ledb} <= disp_c & {3{pwm_on_c}};
      end
   end

endmodule

// File: tb/tb_led_share_sched.sv
// Bench for led_share_sched: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the LED scheduler.
module tb_led_share_sched;

   localparam int unsigned N    = 4;
   localparam int unsigned PW   = 8;
   localparam int unsigned HW   = 32;
   localparam int unsigned STEP = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req;
   logic [3*N-1:0]    colour;
   logic [HW*N-1:0]   hold;
   logic [PW-1:0]     duty;
   logic [N-1:0]      grant;
   logic              busy, ledr, ledg, ledb;

   int errors = 0;
   int checks = 0;

   led_share_sched #(.N_REQ(N), .PWM_W(PW), .HOLD_W(HW), .IDLE_STEP(STEP)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_colour(colour), .i_hold(hold),
      .i_duty(duty), .o_grant(grant), .o_busy(busy), .o_ledr(ledr), .o_ledg(ledg),
      .o_ledb(ledb)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Behavioural model: mode 0=idle,1=show,2=gap; rem = show cycles left
   int         m_st, m_rem, m_last, m_col, m_cnt, m_pwm;
   logic [2:0] m_cap;
   logic [N-1:0] e_grant;
   logic       e_busy;
   logic [2:0] e_led;
   bit         m_valid = 1'b0;

   always @(posedge clk) begin : model
      int w, h, k;
      logic [2:0] disp;
      if (rst) begin
         m_st = 0; m_last = N - 1; m_col = 0; m_cnt = 0; m_pwm = 0; m_rem = 0; m_cap = 0;
         e_grant = '0; e_busy = 1'b0; e_led = 3'b000; m_valid = 1'b1;
      end else if (m_valid) begin
         disp    = (m_st == 0) ? 3'(m_col) : (m_st == 1) ? m_cap : 3'b000;
         e_led   = (m_pwm < int'(duty)) ? disp : 3'b000;
         e_busy  = (m_st != 0);
         e_grant = '0;
         w = -1;
         for (int i = 1; i <= int'(N); i++) begin
            k = (m_last + i) % N;
            if (w < 0 && req[k]) w = k;
         end
         if (m_st == 1) begin
            m_rem--;
            if (m_rem == 0) m_st = 2;
         end else if (w >= 0) begin
            m_st    = 1;
            m_last  = w;
            m_cap   = colour[3*w +: 3];
            h       = int'(hold[HW*w +: HW]);
            m_rem   = (h < 1) ? 1 : h;
            e_grant = N'(1 << w);
         end else if (m_st == 2) begin
            m_st = 0; m_col = 0; m_cnt = 0;
         end else begin
            m_cnt++;
            if (m_cnt == STEP) begin
               m_cnt = 0;
               m_col = (m_col + 1) % 8;
            end
         end
         m_pwm = (m_pwm + 1) % (1 << PW);
      end
   end

   // Every-cycle comparison of DUT against the model
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_grant", 32'(grant), 32'(e_grant));
         chk("model_busy",  32'(busy),  32'(e_busy));
         chk("model_led",   32'({ledr, ledg, ledb}), 32'(e_led));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_grant(output logic [N-1:0] g);
      g = '0;
      for (int i = 0; i < 50 && g == '0; i++) begin
         tick();
         g = grant;
      end
      if (g == '0) chk("grant_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] g;
      logic [2:0]   s;
      logic [2:0]   seq[$];
      int           runs[$];
      logic [N-1:0] gq[$];
      int           gt[$];
      int           exp_seq[9];
      logic [N-1:0] exp_g[5];
      int           gcnt, bcnt, cnt, cr, cg, cb;

      rst = 1'b1; req = '0; colour = '0; hold = '0; duty = 8'd255;

      // Idle colour cycling with no requests
      do_reset();
      gcnt = 0; bcnt = 0;
      for (int i = 0; i < 44; i++) begin
         tick();
         s = {ledr, ledg, ledb};
         if (grant != '0) gcnt++;
         if (busy) bcnt++;
         if (seq.size() == 0 || s != seq[$]) begin
            seq.push_back(s);
            runs.push_back(1);
         end else begin
            runs[$] = runs[$] + 1;
         end
      end
      exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
      if (seq.size() < 9) chk("idle_seq_len", 32'(seq.size()), 32'd9);
      else for (int i = 0; i < 9; i++) chk("idle_seq", 32'(seq[i]), 32'(exp_seq[i]));
      if (runs.size() >= 8) for (int i = 1; i < 8; i++) chk("idle_run", 32'(runs[i]), 32'd4);
      chk("idle_grant", 32'(gcnt), 32'd0);
      chk("idle_busy", 32'(bcnt), 32'd0);

      // Single request, colour 101 for 10 cycles, gap, idle restart
      do_reset();
      colour = '0; colour[2:0] = 3'b101; hold = '0; hold[31:0] = 32'd10;
      req = 4'b0001;
      wait_grant(g);
      req = '0;
      chk("single_grant", 32'(g), 32'h1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if ({ledr, ledg, ledb} == 3'b101) cnt++;
      end
      chk("single_show_len", 32'(cnt), 32'd10);
      tick();
      chk("single_gap_led", 32'({ledr, ledg, ledb}), 32'd0);
      chk("single_gap_busy", 32'(busy), 32'd1);
      tick();
      chk("single_idle_busy", 32'(busy), 32'd0);
      s = 3'b000;
      for (int i = 0; i < 10 && s == 3'b000; i++) begin
         tick();
         s = {ledr, ledg, ledb};
      end
      chk("single_idle_restart", 32'(s), 32'd1);

      // All requesters held: strict rotation, 3 show + 1 gap, never idle
      do_reset();
      hold = {4{32'd3}};
      colour = 12'h9d6;
      req = 4'hf;
      bcnt = 0;
      for (int i = 0; i < 100 && gq.size() < 5; i++) begin
         tick();
         if (gq.size() > 0 && !busy) bcnt++;
         if (grant != '0) begin
            gq.push_back(grant);
            gt.push_back(i);
         end
      end
      req = '0;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      if (gq.size() < 5) chk("rr_count", 32'(gq.size()), 32'd5);
      else begin
         for (int i = 0; i < 5; i++) chk("rr_order", 32'(gq[i]), 32'(exp_g[i]));
         for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(gt[i] - gt[i-1]), 32'd4);
      end
      chk("rr_busy_gap", 32'(bcnt), 32'd0);
      repeat (6) tick();

      // Zero hold on requester 2 with zero duty
      do_reset();
      hold = {4{32'd5}}; hold[HW*2 +: HW] = 32'd0;
      colour = '0; colour[8:6] = 3'b111;
      duty = 8'd0;
      req = 4'b0100;
      wait_grant(g);
      req = '0;
      chk("zero_hold_grant", 32'(g), 32'h4);
      bcnt = 0; cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (busy) bcnt++;
         if ({ledr, ledg, ledb} != 3'b000) cnt++;
      end
      chk("zero_hold_busy", 32'(bcnt), 32'd2);
      chk("zero_duty_led", 32'(cnt), 32'd0);

      // Duty 64 on white: each channel on 64 of 256 cycles
      do_reset();
      duty = 8'd64;
      colour = '0; colour[2:0] = 3'b111;
      hold = '0; hold[31:0] = 32'd600;
      req = 4'b0001;
      wait_grant(g);
      req = '0;
      cr = 0; cg = 0; cb = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         cr += int'(ledr); cg += int'(ledg); cb += int'(ledb);
      end
      chk("pwm64_r", 32'(cr), 32'd64);
      chk("pwm64_g", 32'(cg), 32'd64);
      chk("pwm64_b", 32'(cb), 32'd64);

      // Reset mid-SHOW, then rotation restarts from requester 0's side
      do_reset();
      duty = 8'd255;
      colour = '0; colour[2:0] = 3'b110;
      hold = '0; hold[31:0] = 32'd20;
      req = 4'b0001;
      wait_grant(g);
      req = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_led", 32'({ledr, ledg, ledb}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      gcnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (grant != '0) gcnt++;
      end
      chk("rst_no_grant", 32'(gcnt), 32'd0);
      hold = {4{32'd2}};
      colour = 12'h5a3;
      req = 4'b1010;
      wait_grant(g);
      chk("rst_first_grant", 32'(g), 32'h2);
      req = 4'b1000;
      wait_grant(g);
      chk("rst_second_grant", 32'(g), 32'h8);
      req = '0;
      repeat (8) tick();

      // Randomized traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < int'(N); k++) begin
            hold[HW*k +: HW] = 32'($urandom_range(0, 6));
            if (req[k]) req[k] = ($urandom_range(0, 7) != 0);
            else        req[k] = ($urandom_range(0, 5) == 0);
         end
         colour = 12'($urandom);
         if (i % 300 >= 260) req = '0;
         if (i % 64 == 0) begin
            case ($urandom_range(0, 2))
               0: duty = 8'd0;
               1: duty = 8'd255;
               default: duty = 8'($urandom);
            endcase
         end
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      req = '0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
